banked_memory_controller: RTL and testbench
===========================================

Name: banked_memory_controller

Overview:
Parametrised successor to the two-bank pixel memory controller. It fronts NUM_BANKS identical single-port synchronous-read block RAMs and decodes a bank select into per-bank write enables. It returns read data with a pipeline-aligned bank mux and valid strobe. A hardware fill engine clears or paints a whole bank, one word per cycle. It sits between the drawing/VGA logic and the frame-buffer BRAMs.

Parameters:
DATA_W, 3, pixel word width (RGB bits)
ADDR_W, 15, address width per bank
DEPTH, 19200, words used per bank (160x120); must be <= 2**ADDR_W
NUM_BANKS, 2, number of RAM banks (>= 2)
BANK_W, $clog2(NUM_BANKS), bank select width (derived)

Ports:
iClk  in  1  system clock; all logic on rising edge
iReset  in  1  asynchronous, active-high reset
iReq  in  1  host access request, sampled each cycle
iWren  in  1  1 = write, 0 = read; qualified by iReq
iBankSel  in  BANK_W  target bank for host access and for fill start
iAddress  in  ADDR_W  word address within bank
iData  in  DATA_W  write data; also the fill colour on iFillStart
iFillStart  in  1  start-fill pulse
oQ  out  DATA_W  read data
oRdValid  out  1  one-cycle strobe; oQ valid
oBusy  out  1  fill engine owns the RAMs
oFillDone  out  1  one-cycle pulse at end of fill

Behaviour:
- Reset (async, active-high): oQ=0, oRdValid=0, oBusy=0, oFillDone=0, FSM=IDLE, fill counter=0, latched fill bank/colour=0. RAM contents are not cleared. Reset mid-fill aborts immediately and leaves the bank partially filled.
- Host access is accepted when iReq=1 and oBusy=0. Requests while oBusy=1 are dropped silently, with no oRdValid.
- Write: only bank iBankSel gets wren=1 and stores iData at iAddress. All other banks get wren=0.
- Read latency is 1 cycle. Bank select and a "read-valid" bit are registered with the request. On the next edge, oQ = q of the registered bank and oRdValid=1.
- The output mux uses the registered select, never the live iBankSel, so changing iBankSel has no effect on in-flight data.
- oQ holds its last value when oRdValid=0.
- Out-of-range host access (iBankSel >= NUM_BANKS or iAddress >= DEPTH):
  - writes are dropped;
  - reads still produce oRdValid=1 one cycle later, with oQ=0.
- Back-to-back reads give one result per cycle, in order.
- Fill FSM states are IDLE, FILL, DONE.
  - IDLE: iFillStart=1 with iBankSel < NUM_BANKS latches bank=iBankSel, colour=iData, counter=0, then goes to FILL. iFillStart with an out-of-range bank is ignored.
  - FILL: oBusy=1. Each cycle writes colour to the latched bank at the counter, then increments the counter. When the counter equals DEPTH-1, that final write occurs and the FSM goes to DONE. The fill takes exactly DEPTH cycles.
  - DONE: oBusy=1 and oFillDone=1 for one cycle, then IDLE.
- Same cycle iReq and iFillStart in IDLE: the host access is served that cycle (oBusy still 0) and the fill starts next cycle. A read issued that cycle returns its oRdValid normally.
- iFillStart while oBusy=1 is ignored.
- The fill address counter is ADDR_W bits wide and never wraps, since DEPTH <= 2**ADDR_W.

Decomposition:
- Shared package mem_pkg holds:
  - default DATA_W, ADDR_W, DEPTH, NUM_BANKS;
  - fill FSM state encoding (IDLE=0, FILL=1, DONE=2);
  - the out-of-range read value (zero).
- One natural sub-module, mem_fill_engine: the FSM plus counter, with outputs fill_wren, fill_addr, fill_data, fill_bank, busy and done.
- The top level does bank wren decode, priority mux (fill engine over host), and the registered read-return mux.
- Banks are instantiated in a generate loop of the existing BRAM primitive.

Test Plan:
- Reset then write 3'b101 to bank 1, addr 100; read bank 0 addr 100 and bank 1 addr 100 -> bank 0 returns its prior/zero value, bank 1 returns 3'b101, each with oRdValid exactly 1 cycle after iReq.
- Read bank 1 addr 5, then change iBankSel to 0 the next cycle -> oQ still comes from bank 1; streaming reads addr 0..7 return 8 in-order results on consecutive cycles.
- iFillStart bank 0, colour 3'b010 -> oBusy high for DEPTH+1 cycles, oFillDone single pulse; spot reads of addr 0, 9599, 19199 return 3'b010; bank 1 is unchanged.
- During fill, host write to bank 0 addr 7 and a host read -> write lost (addr 7 reads 3'b010 after fill), no oRdValid; a second iFillStart mid-fill is ignored.
- Assert iReset at fill cycle 50 -> all outputs 0 immediately; addr 0..49 hold the colour, addr 60 does not; a new fill afterwards completes normally.
- Write with iBankSel=NUM_BANKS or addr 19200, then read back -> no bank modified; the read yields oRdValid=1 with oQ=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared defaults and encodings for the banked frame-buffer memory controller.
package mem_pkg;

    // Default geometry: 160x120 pixels of 3-bit RGB, two banks.
    localparam int unsigned DEF_DATA_W    = 3;
    localparam int unsigned DEF_ADDR_W    = 15;
    localparam int unsigned DEF_DEPTH     = 19200;
    localparam int unsigned DEF_NUM_BANKS = 2;

    // Value returned by a read that targets a nonexistent bank or address.
    localparam int unsigned OOR_READ_VALUE = 0;

    // Fill engine states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } fill_state_e;

endpackage

// File: rtl/mem_bram.sv
// Single-port block RAM with synchronous read (read-before-write).
module mem_bram #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 19200
) (
    input  logic              clk_i,
    input  logic              wren_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (wren_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_fill_engine.sv
// Fill engine: paints one whole bank with a constant colour, one word per cycle.
module mem_fill_engine
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
    parameter int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [BANK_W-1:0] bank_i,
    input  logic [DATA_W-1:0] colour_i,
    output logic              fill_wren_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [DATA_W-1:0] fill_data_o,
    output logic [BANK_W-1:0] fill_bank_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [DATA_W-1:0] colour_q, colour_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bank_ok;

    assign bank_ok = 32'(bank_i) < NUM_BANKS;

    // Next-state logic; busy/done are derived from the next state so they leave a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        colour_d = colour_q;
        case (state_q)
            StIdle: begin
                // Out-of-range banks never start a fill.
                if (start_i && bank_ok) begin
                    state_d  = StFill;
                    cnt_d    = '0;
                    bank_d   = bank_i;
                    colour_d = colour_i;
                end
            end
            StFill: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // FSM state, counter, latched target and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bank_q   <= '0;
            colour_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            colour_q <= colour_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign fill_wren_o = (state_q == StFill);
    assign fill_addr_o = cnt_q;
    assign fill_data_o = colour_q;
    assign fill_bank_o = bank_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: rtl/banked_memory_controller.sv
// Front end for NUM_BANKS frame-buffer RAMs: host access, bank decode, read return, fill.
module banked_memory_controller
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
    parameter int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iReq,
    input  logic              iWren,
    input  logic [BANK_W-1:0] iBankSel,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [DATA_W-1:0] iData,
    input  logic              iFillStart,
    output logic [DATA_W-1:0] oQ,
    output logic              oRdValid,
    output logic              oBusy,
    output logic              oFillDone
);

    logic              fill_wren;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic [BANK_W-1:0] fill_bank;
    logic              fill_busy;
    logic              fill_done;

    logic              host_ok;
    logic              host_in_range;

    logic [NUM_BANKS-1:0] bank_wren;
    logic [ADDR_W-1:0]    ram_addr;
    logic [DATA_W-1:0]    ram_wdata;
    logic [DATA_W-1:0]    bank_q [NUM_BANKS];

    logic              rd_valid_q, rd_valid_d;
    logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
    logic              rd_oor_q, rd_oor_d;
    logic [DATA_W-1:0] q_hold_q, q_hold_d;
    logic [DATA_W-1:0] rd_data;

    mem_fill_engine #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_fill (
        .clk_i       (iClk),
        .rst_i       (iReset),
        .start_i     (iFillStart),
        .bank_i      (iBankSel),
        .colour_i    (iData),
        .fill_wren_o (fill_wren),
        .fill_addr_o (fill_addr),
        .fill_data_o (fill_data),
        .fill_bank_o (fill_bank),
        .busy_o      (fill_busy),
        .done_o      (fill_done)
    );

    // Host requests are silently dropped while the fill engine owns the RAMs.
    assign host_ok       = iReq && !fill_busy;
    assign host_in_range = (32'(iBankSel) < NUM_BANKS) && (32'(iAddress) < DEPTH);

    // Shared address/data bus with fill priority, and one-hot bank write enable decode.
    always_comb begin
        ram_addr  = iAddress;
        ram_wdata = iData;
        bank_wren = '0;
        if (fill_wren) begin
            ram_addr  = fill_addr;
            ram_wdata = fill_data;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                if (fill_bank == BANK_W'(b)) begin
                    bank_wren[b] = 1'b1;
                end
            end
        end else if (host_ok && iWren && host_in_range) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                if (iBankSel == BANK_W'(b)) begin
                    bank_wren[b] = 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        mem_bram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_bram (
            .clk_i   (iClk),
            .wren_i  (bank_wren[b]),
            .addr_i  (ram_addr),
            .wdata_i (ram_wdata),
            .rdata_o (bank_q[b])
        );
    end

    // Read tag travels alongside the RAM read so the mux ignores the live iBankSel.
    always_comb begin
        rd_valid_d = host_ok && !iWren;
        rd_bank_d  = rd_bank_q;
        rd_oor_d   = rd_oor_q;
        if (rd_valid_d) begin
            rd_bank_d = iBankSel;
            rd_oor_d  = !host_in_range;
        end
    end

    // Return mux: selected bank, or the fixed value for out-of-range reads.
    always_comb begin
        rd_data = DATA_W'(OOR_READ_VALUE);
        if (!rd_oor_q) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                if (rd_bank_q == BANK_W'(b)) begin
                    rd_data = bank_q[b];
                end
            end
        end
    end

    // RAM q moves with every address change, so oQ is held from a shadow register.
    assign oQ       = rd_valid_q ? rd_data : q_hold_q;
    assign q_hold_d = oQ;

    // Read-return pipeline registers.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            rd_valid_q <= 1'b0;
            rd_bank_q  <= '0;
            rd_oor_q   <= 1'b0;
            q_hold_q   <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_bank_q  <= rd_bank_d;
            rd_oor_q   <= rd_oor_d;
            q_hold_q   <= q_hold_d;
        end
    end

    assign oRdValid  = rd_valid_q;
    assign oBusy     = fill_busy;
    assign oFillDone = fill_done;

endmodule

// File: tb/tb_banked_memory_controller.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus directed literals.
module tb_banked_memory_controller;

    localparam int DW    = 3;
    localparam int AW    = 15;
    localparam int DEPTH = 19200;
    // Three banks so that a 2-bit select can name a nonexistent bank (3).
    localparam int NB    = 3;
    localparam int BW    = 2;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          req    = 1'b0;
    logic          wren   = 1'b0;
    logic          fstart = 1'b0;
    logic [BW-1:0] bsel   = '0;
    logic [AW-1:0] addr   = '0;
    logic [DW-1:0] data   = '0;
    logic [DW-1:0] q;
    logic          rd_valid;
    logic          busy;
    logic          fdone;

    always #5 clk = ~clk;

    banked_memory_controller #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (DEPTH),
        .NUM_BANKS (NB),
        .BANK_W    (BW)
    ) dut (
        .iClk       (clk),
        .iReset     (rst),
        .iReq       (req),
        .iWren      (wren),
        .iBankSel   (bsel),
        .iAddress   (addr),
        .iData      (data),
        .iFillStart (fstart),
        .oQ         (q),
        .oRdValid   (rd_valid),
        .oBusy      (busy),
        .oFillDone  (fdone)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem   [NB][DEPTH];
    bit            m_known [NB][DEPTH];
    int            m_pos = -1;  // -1 idle, 0..DEPTH-1 next word to paint, DEPTH = done cycle
    int            m_bank = 0;
    logic [DW-1:0] m_col = '0;
    bit            m_accept, m_in_rng;
    logic          exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    bit            exp_known = 1'b1;
    logic [DW-1:0] exp_q = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid = 1'b0;
            exp_q     = '0;
            exp_known = 1'b1;
            m_pos     = -1;
        end else begin
            m_accept  = req && (m_pos < 0);
            m_in_rng  = (int'(bsel) < NB) && (int'(addr) < DEPTH);
            exp_valid = m_accept && !wren;
            if (exp_valid) begin
                if (m_in_rng) begin
                    exp_q     = m_mem[bsel][addr];
                    exp_known = m_known[bsel][addr];
                end else begin
                    exp_q     = '0;
                    exp_known = 1'b1;
                end
            end
            if (m_accept && wren && m_in_rng) begin
                m_mem[bsel][addr]   = data;
                m_known[bsel][addr] = 1'b1;
            end
            if (m_pos >= 0 && m_pos < DEPTH) begin
                m_mem[m_bank][m_pos]   = m_col;
                m_known[m_bank][m_pos] = 1'b1;
                m_pos++;
            end else if (m_pos == DEPTH) begin
                m_pos = -1;
            end else if (fstart && int'(bsel) < NB) begin
                m_pos  = 0;
                m_bank = int'(bsel);
                m_col  = data;
            end
        end
        exp_busy = (m_pos >= 0);
        exp_done = (m_pos == DEPTH);
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("rd_valid", rd_valid, exp_valid);
        check("busy", busy, exp_busy);
        check("fill_done", fdone, exp_done);
        if (exp_known) check("q", q, exp_q);
    end

    // ---------------- stimulus helpers (called just after a negedge) ----------------
    task automatic do_write(input int b, input int a, input logic [DW-1:0] d);
        req = 1'b1; wren = 1'b1; bsel = BW'(b); addr = AW'(a); data = d;
        @(negedge clk);
        req = 1'b0; wren = 1'b0;
    endtask

    task automatic read_expect(input string name, input int b, input int a,
                               input logic [DW-1:0] e);
        req = 1'b1; wren = 1'b0; bsel = BW'(b); addr = AW'(a);
        @(negedge clk);
        req = 1'b0;
        check({name, "_valid"}, rd_valid, 1);
        check(name, q, e);
    endtask

    task automatic start_fill(input int b, input logic [DW-1:0] col, input bit with_read,
                              input logic [DW-1:0] rd_exp);
        fstart = 1'b1; bsel = BW'(b); data = col; addr = AW'(100);
        req = with_read; wren = 1'b0;
        @(negedge clk);
        fstart = 1'b0; req = 1'b0;
        if (with_read) begin
            check("start_read_valid", rd_valid, 1);
            check("start_read_q", q, rd_exp);
        end
    endtask

    task automatic wait_fill(input bit inject, input string name);
        int busy_cnt = 0;
        int done_cnt = 0;
        int rv_cnt   = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            if (busy) busy_cnt++;
            if (fdone) done_cnt++;
            if (i > 0 && rd_valid) rv_cnt++;
            if (!busy) break;
            req = 1'b0; wren = 1'b0; fstart = 1'b0;
            if (inject) begin
                if (i == 10) begin
                    req = 1'b1; wren = 1'b1; bsel = 2'd0; addr = AW'(7); data = 3'b111;
                end else if (i == 11) begin
                    req = 1'b1; bsel = 2'd1; addr = AW'(100);
                end else if (i == 12) begin
                    fstart = 1'b1; bsel = 2'd1; data = 3'b111;
                end
            end
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, busy_cnt, DEPTH + 1);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_no_valid_while_busy"}, rv_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_q", q, 0);
        check("reset_valid", rd_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", fdone, 0);
        rst = 1'b0;
        @(negedge clk);

        // Bank decode: same address, different banks.
        do_write(0, 100, 3'b011);
        do_write(1, 100, 3'b101);
        read_expect("rd_b0_a100", 0, 100, 3'b011);
        read_expect("rd_b1_a100", 1, 100, 3'b101);

        // Changing iBankSel after the request must not redirect the in-flight read.
        do_write(1, 5, 3'b110);
        req = 1'b1; wren = 1'b0; bsel = 2'd1; addr = AW'(5);
        @(posedge clk);
        #1 req = 1'b0; bsel = 2'd0;
        @(negedge clk);
        check("sel_change_valid", rd_valid, 1);
        check("sel_change_q", q, 3'b110);
        @(negedge clk);
        check("hold_valid", rd_valid, 0);
        check("hold_q", q, 3'b110);

        // Streaming reads, one result per cycle, in order.
        for (int i = 0; i < 8; i++) do_write(2, i, 3'(i));
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                req = 1'b1; wren = 1'b0; bsel = 2'd2; addr = AW'(i);
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                check("stream_valid", rd_valid, 1);
                check("stream_q", q, 32'(i));
            end else begin
                check("stream_end_valid", rd_valid, 0);
            end
        end

        // Fill bank 0 with a same-cycle read, plus dropped host traffic mid-fill.
        do_write(1, 60, 3'b001);
        do_write(1, 9599, 3'b100);
        start_fill(0, 3'b010, 1'b1, 3'b011);
        wait_fill(1'b1, "fill0");
        read_expect("fill0_a0", 0, 0, 3'b010);
        read_expect("fill0_a9599", 0, 9599, 3'b010);
        read_expect("fill0_a19199", 0, 19199, 3'b010);
        read_expect("fill0_a7_write_lost", 0, 7, 3'b010);
        read_expect("b1_a9599_unchanged", 1, 9599, 3'b100);
        read_expect("b1_a100_unchanged", 1, 100, 3'b101);

        // Reset after 50 painted words aborts the fill.
        start_fill(1, 3'b110, 1'b0, 3'b000);
        repeat (50) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_q", q, 0);
        check("abort_valid", rd_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", fdone, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_expect("abort_a0", 1, 0, 3'b110);
        read_expect("abort_a49", 1, 49, 3'b110);
        read_expect("abort_a60", 1, 60, 3'b001);
        read_expect("abort_a100", 1, 100, 3'b101);

        // A fresh fill after the abort runs to completion.
        start_fill(2, 3'b111, 1'b0, 3'b000);
        wait_fill(1'b0, "fill2");
        read_expect("fill2_a0", 2, 0, 3'b111);
        read_expect("fill2_a19199", 2, 19199, 3'b111);

        // Out-of-range fill start, writes and reads.
        fstart = 1'b1; bsel = 2'd3; data = 3'b101;
        @(negedge clk);
        fstart = 1'b0;
        check("oor_fill_ignored", busy, 0);
        do_write(3, 5, 3'b011);
        do_write(0, 19200, 3'b011);
        read_expect("oor_bank_read", 3, 5, 3'b000);
        read_expect("oor_addr_read", 0, 19200, 3'b000);
        read_expect("oor_b0_a5", 0, 5, 3'b010);
        read_expect("oor_b1_a5", 1, 5, 3'b110);
        read_expect("oor_b2_a5", 2, 5, 3'b111);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
